// File: rtl/fe_power_seq.sv
// fe_power_seq
// Front-end power/reset sequencer. Turns the host reset_ctrl request into a
// safe ordered sequence on the board pins. Power rails come up first and are
// given a settle time. Resets are then released one at a time, with a gap
// after each release. Disables always apply on the next edge. Overcurrent
// faults and USB suspend force the affected rails off.
//
// Ports
//   clk               60 MHz ULPI clock
//   reset_n           asynchronous active-low reset
//   req[7:0]          requested reset_ctrl (1 = disabled / in reset)
//                     7 I2C gate, 6 CI pwr, 5 ant 5V, 4 spare,
//                     3 DTMB, 2 ATSC, 1 tuner, 0 DVB
//   suspend           USB suspend, forces everything off
//   tps_overcurrent_n antenna rail overcurrent, async, active low
//   ci_overcurrent_n  CI rail overcurrent, async, active low
//   fault_clr         one-cycle pulse, clears both fault flags
//   ctrl_o[7:0]       applied reset_ctrl, same encoding as req
//   busy              an enable is pending or a wait is running
//   fault_ci          sticky CI rail overcurrent flag
//   fault_tps         sticky antenna rail overcurrent flag
module fe_power_seq #(
    parameter int PWR_SETTLE_CYC = 600000,
    parameter int RST_GAP_CYC    = 6000,
    parameter int OC_FILT_CYC    = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       suspend,
    input  logic       tps_overcurrent_n,
    input  logic       ci_overcurrent_n,
    input  logic       fault_clr,
    output logic [7:0] ctrl_o,
    output logic       busy,
    output logic       fault_ci,
    output logic       fault_tps
);

    localparam logic [23:0] PWR_LD  = 24'(PWR_SETTLE_CYC - 1);
    localparam logic [23:0] RST_LD  = 24'(RST_GAP_CYC - 1);
    localparam logic [23:0] OC_LAST = 24'(OC_FILT_CYC - 1);
    localparam logic [23:0] OC_MAX  = 24'(OC_FILT_CYC);

    typedef enum logic [1:0] {IDLE, PWR_WAIT, RST_WAIT} state_t;

    state_t      state;
    logic [23:0] cnt;
    logic        armed;
    logic [7:0]  tgt;
    logic [7:0]  pend;
    logic [7:0]  rel;

    // Overcurrent path. Index 0 is the antenna rail, index 1 is the CI rail.
    logic [1:0]       oc_s1;
    logic [1:0]       oc_s2;
    logic [1:0][23:0] filt;
    logic [1:0]       det;

    always_comb begin
        for (int i = 0; i < 2; i++)
            det[i] = !oc_s2[i] && (filt[i] == OC_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oc_s1     <= 2'b11;
            oc_s2     <= 2'b11;
            filt      <= '0;
            fault_tps <= 1'b0;
            fault_ci  <= 1'b0;
        end else begin
            oc_s1 <= {ci_overcurrent_n, tps_overcurrent_n};
            oc_s2 <= oc_s1;
            for (int i = 0; i < 2; i++) begin
                if (oc_s2[i])
                    filt[i] <= '0;
                else if (filt[i] != OC_MAX)
                    filt[i] <= filt[i] + 24'd1;  // saturate, no wrap
            end
            // A detection in the same cycle as a clear wins.
            fault_tps <= det[0] | (fault_tps & ~fault_clr);
            fault_ci  <= det[1] | (fault_ci & ~fault_clr);
        end
    end

    // Target and pending enables. Reset release order: 1, 0, 2, 3, 7, 4.
    always_comb begin
        tgt = suspend ? 8'hFF : req;
        if (fault_ci)  tgt[6] = 1'b1;
        if (fault_tps) tgt[5] = 1'b1;
        pend = ctrl_o & ~tgt;
        rel  = '0;
        if      (pend[1]) rel[1] = 1'b1;
        else if (pend[0]) rel[0] = 1'b1;
        else if (pend[2]) rel[2] = 1'b1;
        else if (pend[3]) rel[3] = 1'b1;
        else if (pend[7]) rel[7] = 1'b1;
        else if (pend[4]) rel[4] = 1'b1;
    end

    // Pending bits are zero in tgt, so OR-ing tgt in never re-sets a bit the
    // FSM is clearing in the same step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_o <= 8'hFF;
            state  <= IDLE;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (suspend) begin
                ctrl_o <= 8'hFF;
                state  <= IDLE;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pend[6] | pend[5]) begin
                            ctrl_o <= (ctrl_o | tgt) & ~(pend & 8'h60);
                            cnt    <= PWR_LD;
                            state  <= PWR_WAIT;
                        end else if (pend != 8'h00) begin
                            ctrl_o <= (ctrl_o | tgt) & ~rel;
                            cnt    <= RST_LD;
                            state  <= RST_WAIT;
                        end else begin
                            ctrl_o <= ctrl_o | tgt;
                        end
                    end
                    default: begin
                        ctrl_o <= ctrl_o | tgt;
                        if (cnt == 24'd0)
                            state <= IDLE;
                        else
                            cnt <= cnt - 24'd1;
                    end
                endcase
            end
        end
    end

    // Held low from reset until the first edge so busy reads 0 in reset
    // even though a pending request is already visible.
    assign busy = armed & ((state != IDLE) | (pend != 8'h00));

endmodule

// File: tb/tb_fe_power_seq.sv
module tb_fe_power_seq;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic       suspend;
    logic       tps_overcurrent_n;
    logic       ci_overcurrent_n;
    logic       fault_clr;
    logic [7:0] ctrl_o;
    logic       busy;
    logic       fault_ci;
    logic       fault_tps;

    fe_power_seq #(
        .PWR_SETTLE_CYC(10),
        .RST_GAP_CYC   (4),
        .OC_FILT_CYC   (3)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .suspend          (suspend),
        .tps_overcurrent_n(tps_overcurrent_n),
        .ci_overcurrent_n (ci_overcurrent_n),
        .fault_clr        (fault_clr),
        .ctrl_o           (ctrl_o),
        .busy             (busy),
        .fault_ci         (fault_ci),
        .fault_tps        (fault_tps)
    );

    typedef struct {
        int         cyc;
        logic [9:0] val;   // {fault_ci, fault_tps, ctrl_o}
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev = 10'h0FF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_ev(input int c, input logic fci, input logic ftps, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = {fci, ftps, v};
        sbq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Full power-up from all-disabled with req=00, first edge at t+1.
    task automatic push_pwrup(input int t);
        expect_ev(t + 1,  1'b0, 1'b0, 8'h9F);
        expect_ev(t + 12, 1'b0, 1'b0, 8'h9D);
        expect_ev(t + 17, 1'b0, 1'b0, 8'h9C);
        expect_ev(t + 22, 1'b0, 1'b0, 8'h98);
        expect_ev(t + 27, 1'b0, 1'b0, 8'h90);
        expect_ev(t + 32, 1'b0, 1'b0, 8'h10);
        expect_ev(t + 37, 1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: every change of the observed outputs is an output event that
    // must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t e;
        cur = {fault_ci, fault_tps, ctrl_o};
        if (mon_en && cur !== prev) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %0h expected no change (cycle %0d)", cur, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.val !== cur || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event: got %0h at cycle %0d expected %0h at cycle %0d",
                             cur, cyc, e.val, e.cyc);
                end
            end
        end
        prev = cur;
    end

    initial begin
        int t, s, c, g, f, d, e, r, x, y;
        reset_n = 1'b0;
        req = 8'h00;
        suspend = 1'b0;
        tps_overcurrent_n = 1'b1;
        ci_overcurrent_n = 1'b1;
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 32'(ctrl_o), 32'hFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fault_ci", 32'(fault_ci), 0);
        chk("rst_fault_tps", 32'(fault_tps), 0);
        #2 mon_en = 1'b1;

        // Power-up sequence.
        @(negedge clk);
        reset_n = 1'b1;
        t = cyc;
        push_pwrup(t);
        wait_until(t + 40);
        chk("pwrup_busy_wait", 32'(busy), 1);
        wait_until(t + 41);
        chk("pwrup_busy_done", 32'(busy), 0);
        wait_until(t + 45);

        // Suspend for 20 cycles, then a full restart.
        s = cyc;
        suspend = 1'b1;
        expect_ev(s + 1, 1'b0, 1'b0, 8'hFF);
        wait_until(s + 5);
        chk("susp_busy", 32'(busy), 0);
        wait_until(s + 20);
        suspend = 1'b0;
        push_pwrup(s + 20);
        wait_until(s + 62);

        // CI overcurrent held low 5 cycles.
        c = cyc;
        ci_overcurrent_n = 1'b0;
        expect_ev(c + 5, 1'b1, 1'b0, 8'h00);
        expect_ev(c + 6, 1'b1, 1'b0, 8'h40);
        wait_until(c + 5);
        ci_overcurrent_n = 1'b1;
        wait_until(c + 10);
        chk("oc_fault_ci", 32'(fault_ci), 1);

        // Two-cycle glitch on the antenna rail must be filtered.
        g = cyc;
        tps_overcurrent_n = 1'b0;
        wait_until(g + 2);
        tps_overcurrent_n = 1'b1;
        wait_until(g + 12);
        chk("glitch_fault_tps", 32'(fault_tps), 0);
        chk("glitch_ctrl", 32'(ctrl_o), 32'h40);

        // Fault clear with the input high: CI rail comes back up.
        f = cyc;
        fault_clr = 1'b1;
        expect_ev(f + 1, 1'b0, 1'b0, 8'h40);
        expect_ev(f + 2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        fault_clr = 1'b0;
        chk("clr_busy_pend", 32'(busy), 1);
        wait_until(f + 11);
        chk("clr_busy_wait", 32'(busy), 1);
        wait_until(f + 12);
        chk("clr_busy_done", 32'(busy), 0);
        wait_until(f + 15);

        // Clear coincident with detection: detection wins.
        d = cyc;
        ci_overcurrent_n = 1'b0;
        expect_ev(d + 5, 1'b1, 1'b0, 8'h00);
        expect_ev(d + 6, 1'b1, 1'b0, 8'h40);
        wait_until(d + 4);
        fault_clr = 1'b1;
        wait_until(d + 5);
        fault_clr = 1'b0;
        ci_overcurrent_n = 1'b1;
        wait_until(d + 8);
        chk("clr_vs_det", 32'(fault_ci), 1);

        // Async reset in the middle of PWR_WAIT.
        e = cyc;
        fault_clr = 1'b1;
        expect_ev(e + 1, 1'b0, 1'b0, 8'h40);
        expect_ev(e + 2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        fault_clr = 1'b0;
        wait_until(e + 5);
        chk("pwrwait_busy", 32'(busy), 1);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_ctrl", 32'(ctrl_o), 32'hFF);
        chk("arst_busy", 32'(busy), 0);
        @(negedge clk);
        #2 mon_en = 1'b1;

        // Disable during the first reset gap: bit 0 is skipped.
        @(negedge clk);
        reset_n = 1'b1;
        r = cyc;
        expect_ev(r + 1,  1'b0, 1'b0, 8'h9F);
        expect_ev(r + 12, 1'b0, 1'b0, 8'h9D);
        expect_ev(r + 17, 1'b0, 1'b0, 8'h99);
        expect_ev(r + 22, 1'b0, 1'b0, 8'h91);
        expect_ev(r + 27, 1'b0, 1'b0, 8'h11);
        expect_ev(r + 32, 1'b0, 1'b0, 8'h01);
        wait_until(r + 13);
        req = 8'h01;
        wait_until(r + 40);
        chk("skip_ctrl", 32'(ctrl_o), 32'h01);
        chk("skip_busy", 32'(busy), 0);

        // Disable from IDLE is one cycle, then enable from IDLE is one cycle.
        x = cyc;
        req = 8'h03;
        expect_ev(x + 1, 1'b0, 1'b0, 8'h03);
        wait_until(x + 3);
        y = cyc;
        req = 8'h00;
        expect_ev(y + 1, 1'b0, 1'b0, 8'h01);
        expect_ev(y + 6, 1'b0, 1'b0, 8'h00);
        wait_until(y + 12);

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
